uart_rx: RTL and testbench

//  Serial receiver; the stage directly downstream of uart_tx on the line.

---
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start/data/parity/stop deframing).
// Optional build macro UART_RX_MAJORITY_EN: each bit is the majority of three
// samples around the bit centre instead of a single centre sample.
module uart_rx #(
  parameter int unsigned OSR      = 16,
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pls_rx,
  input  logic       uart_rxd,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic [3:0] data_len,
  input  logic [1:0] stop_len,
  output logic [7:0] data_rx,
  output logic       vld_rx,
  output logic       err_parity,
  output logic       err_frame,
  output logic       busy_rx
);

  localparam int unsigned CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] START_CTR = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] BIT_CTR   = CW'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  logic [SYNC_LEN-1:0] sync_q;
  logic              rxd_s;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        bidx_q;
  logic              stop_idx_q;
  logic [7:0]        data_q;
  logic              perr_q;
  logic              ferr_q;
  logic              armed_q;
  logic [2:0]        len_m1_q;
  logic              par_en_q;
  logic              par_even_q;
  logic              stop2_q;

  logic [CW-1:0]     centre_c;
  logic              at_centre_c;
  logic              bit_evt_c;
  logic              bit_val_c;
  logic              ferr_fin_c;

  // Line synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_LEN-2:0], uart_rxd};
  end

  assign rxd_s = sync_q[SYNC_LEN-1];

  // Bit-centre detection for the current state
  always_comb begin
    centre_c    = (state_q == S_START) ? START_CTR : BIT_CTR;
    at_centre_c = pls_rx && (state_q != S_IDLE) && (cnt_q == centre_c);
  end

`ifdef UART_RX_MAJORITY_EN
  logic s0_q;
  logic s1_q;
  logic pend_q;

  // Capture centre-1 and centre samples; the vote completes on the following tick
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
      pend_q <= 1'b0;
    end else if (pls_rx && state_q != S_IDLE) begin
      if (cnt_q == CW'(centre_c - CW'(1))) s0_q <= rxd_s;
      if (at_centre_c) begin
        s1_q   <= rxd_s;
        pend_q <= 1'b1;
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

  // Majority of centre-1, centre, centre+1
  always_comb begin
    bit_evt_c = pls_rx && pend_q;
    bit_val_c = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
  end
`else
  // Single centre sample
  always_comb begin
    bit_evt_c = at_centre_c;
    bit_val_c = rxd_s;
  end
`endif

  assign ferr_fin_c = ferr_q | ~bit_val_c;

  // Receive FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bidx_q     <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b1;
      len_m1_q   <= 3'd7;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      stop2_q    <= 1'b0;
      data_rx    <= '0;
      vld_rx     <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      busy_rx    <= 1'b0;
    end else begin
      vld_rx <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!armed_q) begin
            if (rxd_s) armed_q <= 1'b1;
          end else if (!rxd_s) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            bidx_q     <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_rx    <= 1'b1;
            len_m1_q   <= (data_len >= 4'd5 && data_len <= 4'd8) ? 3'(data_len - 4'd1) : 3'd7;
            par_en_q   <= parity_en;
            par_even_q <= parity_even;
            stop2_q    <= (stop_len >= 2'd2);
          end
        end
        default: begin
          if (pls_rx) cnt_q <= (cnt_q == centre_c) ? '0 : CW'(cnt_q + CW'(1));
          if (bit_evt_c) begin
            case (state_q)
              S_START: begin
                if (bit_val_c) begin
                  state_q <= S_IDLE;
                  busy_rx <= 1'b0;
                end else begin
                  state_q <= S_DATA;
                end
              end
              S_DATA: begin
                data_q[bidx_q] <= bit_val_c;
                if (bidx_q == len_m1_q) state_q <= par_en_q ? S_PARITY : S_STOP;
                else                    bidx_q  <= bidx_q + 3'd1;
              end
              S_PARITY: begin
                perr_q  <= ((^data_q) ^ bit_val_c) != !par_even_q;
                state_q <= S_STOP;
              end
              S_STOP: begin
                if (stop_idx_q == stop2_q) begin
                  vld_rx     <= 1'b1;
                  data_rx    <= data_q;
                  err_parity <= perr_q;
                  err_frame  <= ferr_fin_c;
                  armed_q    <= ~ferr_fin_c;
                  busy_rx    <= 1'b0;
                  state_q    <= S_IDLE;
                end else begin
                  stop_idx_q <= 1'b1;
                  ferr_q     <= ferr_fin_c;
                end
              end
              default: begin
                state_q <= S_IDLE;
                busy_rx <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: line-level frame generator with scoreboard for uart_rx.
module tb_uart_rx;

  localparam int unsigned OSR = 16;
  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pls_rx = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_even = 1'b0;
  logic [3:0] data_len = 4'd8;
  logic [1:0] stop_len = 2'd1;
  logic [7:0] data_rx;
  logic       vld_rx;
  logic       err_parity;
  logic       err_frame;
  logic       busy_rx;

  int n_cmp = 0;
  int n_bad = 0;
  int tdiv  = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] len;
    logic       pen;
    logic       pev;
    logic [1:0] sl;
    logic       bad;
    logic [7:0] xd;
    logic       xp;
    logic       xf;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[8];

  uart_rx #(.OSR(OSR), .SYNC_LEN(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pls_rx      (pls_rx),
    .uart_rxd    (uart_rxd),
    .parity_en   (parity_en),
    .parity_even (parity_even),
    .data_len    (data_len),
    .stop_len    (stop_len),
    .data_rx     (data_rx),
    .vld_rx      (vld_rx),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .busy_rx     (busy_rx)
  );

  always #5 clk = ~clk;

  // Oversample tick: one pulse every DIV clocks
  always @(posedge clk) begin
    tdiv   <= (tdiv == DIV - 1) ? 0 : tdiv + 1;
    pls_rx <= (tdiv == DIV - 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: pop and compare on every vld_rx
  always @(negedge clk) begin
    if (vld_rx) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_rx", 32'(data_rx), 32'(e.d));
        chk("err_parity", 32'(err_parity), 32'(e.p));
        chk("err_frame", 32'(err_frame), 32'(e.f));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!pls_rx) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk) uart_rxd = v;
    wait_ticks(OSR);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [3:0] len, input logic pen,
                            input logic pev, input logic [1:0] sl, input logic bad);
    int         eff_len;
    int         eff_sl;
    logic [7:0] m;
    logic       p;
    eff_len = (len >= 4'd5 && len <= 4'd8) ? int'(len) : 8;
    eff_sl  = (sl >= 2'd2) ? 2 : 1;
    m = d & 8'(~(9'h1FF << eff_len));
    p = (^m) ^ ~pev;
    if (bad) p = ~p;
    data_len    = len;
    parity_en   = pen;
    parity_even = pev;
    stop_len    = sl;
    @(negedge clk) uart_rxd = 1'b0;
    wait_ticks(OSR / 2);
    data_len    = (len == 4'd5) ? 4'd8 : 4'd5;
    parity_en   = ~pen;
    parity_even = ~pev;
    stop_len    = (sl >= 2'd2) ? 2'd1 : 2'd2;
    wait_ticks(OSR / 2);
    for (int i = 0; i < eff_len; i++) send_bit(d[i]);
    if (pen) send_bit(p);
    for (int i = 0; i < eff_sl; i++) send_bit(1'b1);
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.d = d;
    e.p = p;
    e.f = f;
    exp_q.push_back(e);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy;
    //          d      len   pen   pev   sl    bad   xd     xp    xf
    tbl[0] = '{8'h0F, 4'd8, 1'b1, 1'b1, 2'd2, 1'b0, 8'h0F, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 4'd7, 1'b1, 1'b0, 2'd1, 1'b0, 8'h55, 1'b0, 1'b0};
    tbl[2] = '{8'h2A, 4'd7, 1'b1, 1'b0, 2'd1, 1'b0, 8'h2A, 1'b0, 1'b0};
    tbl[3] = '{8'h01, 4'd8, 1'b1, 1'b1, 2'd1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 4'd5, 1'b0, 1'b0, 2'd1, 1'b0, 8'h1F, 1'b0, 1'b0};
    tbl[5] = '{8'h2D, 4'd6, 1'b1, 1'b1, 2'd1, 1'b0, 8'h2D, 1'b0, 1'b0};
    tbl[6] = '{8'hC3, 4'd9, 1'b0, 1'b0, 2'd1, 1'b0, 8'hC3, 1'b0, 1'b0};
    tbl[7] = '{8'h3C, 4'd8, 1'b1, 1'b0, 2'd0, 1'b0, 8'h3C, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_data_rx", 32'(data_rx), 32'h0);
    chk("rst_vld_rx", 32'(vld_rx), 32'h0);
    chk("rst_err_parity", 32'(err_parity), 32'h0);
    chk("rst_err_frame", 32'(err_frame), 32'h0);
    chk("rst_busy_rx", 32'(busy_rx), 32'h0);
    wait_ticks(2 * OSR);

    // Back-to-back frames from the table
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].xd, tbl[i].xp, tbl[i].xf);
      send_frame(tbl[i].d, tbl[i].len, tbl[i].pen, tbl[i].pev, tbl[i].sl, tbl[i].bad);
    end
    wait_ticks(OSR);
    chk("data_rx_hold", 32'(data_rx), 32'h3C);

    // Break: line low for 12 bit times
    data_len = 4'd8; parity_en = 1'b0; parity_even = 1'b0; stop_len = 2'd1;
    push(8'h00, 1'b0, 1'b1);
    @(negedge clk) uart_rxd = 1'b0;
    wait_ticks(11 * OSR);
    chk("break_no_restart", 32'(busy_rx), 32'h0);
    chk("break_err_frame_hold", 32'(err_frame), 32'h1);
    wait_ticks(OSR);
    @(negedge clk) uart_rxd = 1'b1;
    wait_ticks(2 * OSR);

    // Short low glitch: false start
    saw_busy = 1'b0;
    @(negedge clk) uart_rxd = 1'b0;
    wait_ticks(OSR / 4);
    @(negedge clk) uart_rxd = 1'b1;
    for (int i = 0; i < OSR * DIV; i++) begin
      @(negedge clk);
      if (busy_rx) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk("glitch_busy_low", 32'(busy_rx), 32'h0);

    // Re-armed after break: a normal frame is received
    push(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 2'd1, 1'b0);
    wait_ticks(OSR);

    // Reset during data bits: frame discarded
    data_len = 4'd8; parity_en = 1'b0; stop_len = 2'd1;
    @(negedge clk) uart_rxd = 1'b0;
    wait_ticks(OSR);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("midrst_data_rx", 32'(data_rx), 32'h0);
    chk("midrst_busy_rx", 32'(busy_rx), 32'h0);
    chk("midrst_err_frame", 32'(err_frame), 32'h0);
    uart_rxd = 1'b1;
    @(negedge clk) rst = 1'b0;
    wait_ticks(3 * OSR);
    chk("midrst_idle", 32'(busy_rx), 32'h0);
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 2'd1, 1'b0);

    wait_ticks(4 * OSR);
    chk("all_frames_seen", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
